// File: rtl/byte_serial_adder_ctrl_pkg.sv
// Shared definitions for the byte-serial wide adder sequencer.
// Holds the FSM encodings, the byte width and the signed-overflow rule.
package byte_serial_adder_ctrl_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Two's-complement overflow: same-signed operands yielding a differently signed result.
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/byte_serial_adder_ctrl_if.sv
// Request/result bundle between the ALU front end and the wide-add sequencer.
interface byte_serial_adder_ctrl_if #(
  parameter int unsigned NBYTES = 4
);
  import byte_serial_adder_ctrl_pkg::*;

  localparam int unsigned W = BYTE_W * NBYTES;

  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout, ovf
  );

endinterface

// File: rtl/byte_serial_adder_ctrl_byte_adder.sv
// Shared 8-bit adder slice with carry in/out; purely combinational.
module byte_serial_adder_ctrl_byte_adder
  import byte_serial_adder_ctrl_pkg::*;
(
  input  logic [BYTE_W-1:0] i_a,
  input  logic [BYTE_W-1:0] i_b,
  input  logic              i_cin,
  output logic [BYTE_W-1:0] o_sum_c,
  output logic              o_carry_c
);

  always_comb begin
    {o_carry_c, o_sum_c} = {1'b0, i_a} + {1'b0, i_b} + {{BYTE_W{1'b0}}, i_cin};
  end

endmodule

// File: rtl/byte_serial_adder_ctrl.sv
// Wide adder built by stepping one byte adder over the operands, LSB first,
// chaining the carry through a register between bytes.
module byte_serial_adder_ctrl
  import byte_serial_adder_ctrl_pkg::*;
#(
  parameter int unsigned NBYTES = 4,
  parameter int unsigned IDXW   = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  byte_serial_adder_ctrl_if.slave  bus
);

  localparam int unsigned      W        = BYTE_W * NBYTES;
  localparam logic [IDXW-1:0]  LAST_IDX = IDXW'(NBYTES - 1);

  state_t              r_state;
  state_t              w_next_state;
  logic [IDXW-1:0]     r_idx;
  logic                r_carry;
  logic [W-1:0]        r_op_a;
  logic [W-1:0]        r_op_b;
  logic [W-1:0]        r_sum;
  logic                r_cout;
  logic                r_ovf;
  logic                r_busy;
  logic                r_done;

  logic [BYTE_W-1:0]   w_a_byte;
  logic [BYTE_W-1:0]   w_b_byte;
  logic [BYTE_W-1:0]   w_sum_byte;
  logic                w_carry;
  logic                w_last;

  assign w_a_byte = r_op_a[BYTE_W*r_idx +: BYTE_W];
  assign w_b_byte = r_op_b[BYTE_W*r_idx +: BYTE_W];
  assign w_last   = (r_idx == LAST_IDX);

  byte_serial_adder_ctrl_byte_adder u_byte_adder (
    .i_a       (w_a_byte),
    .i_b       (w_b_byte),
    .i_cin     (r_carry),
    .o_sum_c   (w_sum_byte),
    .o_carry_c (w_carry)
  );

  // Next-state logic; unreachable encodings fall back to IDLE.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (bus.start) w_next_state = ST_RUN;
      ST_RUN:  if (w_last)    w_next_state = ST_DONE;
      ST_DONE:                w_next_state = ST_IDLE;
      default:                w_next_state = ST_IDLE;
    endcase
  end

  // State register; busy/done are registered decodes of the upcoming state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_busy  <= (w_next_state != ST_IDLE);
      r_done  <= (w_next_state == ST_DONE);
    end
  end

  // Operand latches, byte index, carry chain and result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_op_a  <= '0;
      r_op_b  <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_op_a  <= bus.a;
            r_op_b  <= bus.b;
            r_carry <= bus.cin;
            r_idx   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
          end
        end
        ST_RUN: begin
          r_sum[BYTE_W*r_idx +: BYTE_W] <= w_sum_byte;
          r_carry                       <= w_carry;
          if (w_last) begin
            // Index parks at zero so it never leaves 0..NBYTES-1.
            r_idx  <= '0;
            r_cout <= w_carry;
            r_ovf  <= signed_ovf(r_op_a[W-1], r_op_b[W-1], w_sum_byte[BYTE_W-1]);
          end else begin
            r_idx  <= r_idx + IDXW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.sum  = r_sum;
  assign bus.cout = r_cout;
  assign bus.ovf  = r_ovf;

endmodule

// File: tb/tb_byte_serial_adder_ctrl.sv
// Directed bench for the byte-serial adder with a cycle-timing reference model.
module tb_byte_serial_adder_ctrl;
  import byte_serial_adder_ctrl_pkg::*;

  localparam int NBYTES = 4;
  localparam int W      = 32;

  logic clk;
  logic rst;

  byte_serial_adder_ctrl_if #(.NBYTES(NBYTES)) bus ();

  byte_serial_adder_ctrl #(.NBYTES(NBYTES), .IDXW(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors;
  int miscompares;

  // Reference: {ovf, cout, sum} of a plain (W+1)-bit add.
  function automatic logic [W+1:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic c);
    logic [W:0] t;
    t = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    return {((x[W-1] == y[W-1]) && (t[W-1] != x[W-1])), t};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: an accepted request is busy for NBYTES+1 cycles, done in the last,
  // and a new request is only taken NBYTES+2 edges after the previous one.
  int             cyc;
  int             acc;
  bit             active;
  bit             live;
  logic [W+1:0]   res;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      active = 1'b0;
    end else if (!active || (cyc - acc) >= NBYTES + 2) begin
      if (bus.start) begin
        active = 1'b1;
        acc    = cyc;
        res    = ref_add(bus.a, bus.b, bus.cin);
      end
    end
    live = 1'b1;
  end

  always @(negedge clk) begin
    if (live) begin
      int m;
      m = cyc - acc;
      if (active && m <= NBYTES) begin
        chk("busy", 64'(bus.busy), 64'(1'b1));
        chk("done", 64'(bus.done), 64'(m == NBYTES));
      end else begin
        chk("busy", 64'(bus.busy), 64'(1'b0));
        chk("done", 64'(bus.done), 64'(1'b0));
      end
      if (!active) begin
        chk("sum_idle", 64'(bus.sum), 64'(0));
        chk("cout_idle", 64'(bus.cout), 64'(0));
        chk("ovf_idle", 64'(bus.ovf), 64'(0));
      end else if (m >= NBYTES) begin
        chk("sum", 64'(bus.sum), 64'(res[W-1:0]));
        chk("cout", 64'(bus.cout), 64'(res[W]));
        chk("ovf", 64'(bus.ovf), 64'(res[W+1]));
      end else begin
        if (m == 0) chk("sum_clr", 64'(bus.sum), 64'(0));
        chk("cout_run", 64'(bus.cout), 64'(0));
        chk("ovf_run", 64'(bus.ovf), 64'(0));
      end
    end
  end

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                        input logic [W-1:0] es, input logic ec, input logic eo,
                        input string tag);
    int lat;
    bit got;
    got = 1'b0;
    lat = 0;
    @(negedge clk);
    bus.a = a; bus.b = b; bus.cin = c; bus.start = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 1) bus.start = 1'b0;
      if (bus.done === 1'b1) begin
        lat = i;
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      chk({tag, "_timeout"}, 64'(0), 64'(1));
    end else begin
      chk({tag, "_latency"}, 64'(lat), 64'(NBYTES + 1));
      chk({tag, "_sum"}, 64'(bus.sum), 64'(es));
      chk({tag, "_cout"}, 64'(bus.cout), 64'(ec));
      chk({tag, "_ovf"}, 64'(bus.ovf), 64'(eo));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ndone;
    logic [W-1:0] dsum;
    vectors = 0; miscompares = 0;
    cyc = 0; acc = 0; active = 1'b0; live = 1'b0; res = '0;
    rst = 1'b1;
    bus.start = 1'b1; bus.a = 32'hDEADBEEF; bus.b = 32'h12345678; bus.cin = 1'b1;

    // Pin the reference model itself.
    chk("pin_ovf", 64'(ref_add(32'h7FFFFFFF, 32'h00000001, 1'b0)), 64'h2_8000_0000);
    chk("pin_carry", 64'(ref_add(32'hFFFFFFFF, 32'h00000001, 1'b0)), 64'h1_0000_0000);

    // Reset held with start asserted.
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(bus.busy), 64'(0));
    chk("rst_done", 64'(bus.done), 64'(0));
    chk("rst_sum", 64'(bus.sum), 64'(0));
    chk("rst_cout", 64'(bus.cout), 64'(0));
    chk("rst_ovf", 64'(bus.ovf), 64'(0));
    rst = 1'b0; bus.start = 1'b0;
    repeat (3) @(negedge clk);

    run_op(32'h00000000, 32'h00000001, 1'b0, 32'h00000001, 1'b0, 1'b0, "t2");
    run_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0, "t3a");
    run_op(32'h000000FF, 32'h00000000, 1'b1, 32'h00000100, 1'b0, 1'b0, "t3b");
    run_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1, "t4a");
    run_op(32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1, "t4b");
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, "allones");

    // Restart attempt mid-RUN and operand change after acceptance.
    @(negedge clk);
    bus.a = 32'h01010101; bus.b = 32'h02020202; bus.cin = 1'b0; bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    @(negedge clk); bus.start = 1'b1; bus.a = 32'hFFFFFFFF;
    @(negedge clk); bus.start = 1'b0; bus.a = 32'h12345678;
    ndone = 0; dsum = '0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        ndone++;
        dsum = bus.sum;
      end
    end
    chk("t5_ndone", 64'(ndone), 64'(1));
    chk("t5_sum", 64'(dsum), 64'h03030303);

    // Reset in the middle of RUN.
    @(negedge clk);
    bus.a = 32'hAAAAAAAA; bus.b = 32'h55555555; bus.cin = 1'b1; bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("t6_busy", 64'(bus.busy), 64'(0));
    chk("t6_sum", 64'(bus.sum), 64'(0));
    repeat (6) @(negedge clk);
    run_op(32'h12345678, 32'h87654321, 1'b1, 32'h9999999A, 1'b0, 1'b0, "t6_fresh");

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
